dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// It sits between the CPU word port and a 256-bit line memory, and starts the
// enable/write/ack line transactions that the memory answers.
module dcache_ctrl #(
    parameter int LINES  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [255:0]      mem_data_i,
    input  logic              mem_ack_i,
    output logic [255:0]      mem_data_o,
    output logic [31:0]       mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 5;

    typedef enum logic [1:0] {IDLE, WB_REQ, RD_REQ, FILL} state_t;

    state_t state_q, state_d;

    // Line storage; valid/dirty are reset, tags and data are not.
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [255:0]     data_q [LINES];

    // Registered memory-side request.
    logic         mem_enable_q, mem_enable_d;
    logic         mem_write_q, mem_write_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [255:0] mem_data_q, mem_data_d;

    logic [2:0]        word;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic              req;
    logic              hit;
    logic              miss;
    logic              victim_dirty;
    logic [255:0]      cur_line;
    logic [255:0]      store_line;
    logic [ADDR_W-1:0] req_line_addr;
    logic [ADDR_W-1:0] victim_line_addr;
    logic              unused_addr_bits;

    assign word             = p1_addr_i[4:2];
    assign idx              = p1_addr_i[5 +: IDX_W];
    assign req_tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign unused_addr_bits = ^p1_addr_i[1:0];

    assign req          = p1_MemRead_i | p1_MemWrite_i;
    assign hit          = req & valid_q[idx] & (tag_q[idx] == req_tag);
    assign miss         = req & ~hit;
    assign victim_dirty = valid_q[idx] & dirty_q[idx];
    assign cur_line     = data_q[idx];

    assign req_line_addr    = {req_tag, idx, 5'b0};
    assign victim_line_addr = {tag_q[idx], idx, 5'b0};

    // Store merge: replace only the addressed 32-bit word of the resident line.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_merge
            assign store_line[gi*32 +: 32] = (word == 3'(gi)) ? p1_data_i : cur_line[gi*32 +: 32];
        end
    endgenerate

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: write back a dirty victim first, then read the line, then fill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss) state_d = victim_dirty ? WB_REQ : RD_REQ;
            WB_REQ:  if (mem_ack_i) state_d = RD_REQ;
            RD_REQ:  if (mem_ack_i) state_d = FILL;
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: CPU-side stall/data and next values of the memory request registers.
    always_comb begin
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        p1_stall_o   = (state_q != IDLE) | miss;
        p1_data_o    = cur_line[{word, 5'b0} +: 32];
        case (state_q)
            IDLE: begin
                mem_enable_d = 1'b0;
                if (miss) begin
                    mem_enable_d = 1'b1;
                    if (victim_dirty) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = 32'(victim_line_addr);
                        mem_data_d  = cur_line;
                    end else begin
                        mem_write_d = 1'b0;
                        mem_addr_d  = 32'(req_line_addr);
                    end
                end
            end
            // Enable stays high: the write ack rolls straight into the line read.
            WB_REQ: begin
                if (mem_ack_i) begin
                    mem_write_d = 1'b0;
                    mem_addr_d  = 32'(req_line_addr);
                end
            end
            // Drop enable on the read ack so the memory cannot start a second read.
            RD_REQ: begin
                if (mem_ack_i) mem_enable_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Memory request registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    // Valid/dirty bookkeeping: store hits dirty the line, write-back and fill clean it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                IDLE:    if (hit && p1_MemWrite_i) dirty_q[idx] <= 1'b1;
                WB_REQ:  if (mem_ack_i) dirty_q[idx] <= 1'b0;
                FILL: begin
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Line data and tag arrays: store-hit word merge and refill from memory.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == IDLE && hit && p1_MemWrite_i) begin
                data_q[idx] <= store_line;
            end else if (state_q == FILL) begin
                data_q[idx] <= mem_data_i;
                tag_q[idx]  <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed vector table, reset-abort sequence and a randomized
// run against a word-level golden memory plus a tag/dirty reference model.
module tb_dcache_ctrl;
    localparam int LINES  = 32;
    localparam int ADDR_W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;

    dcache_ctrl #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- line memory model ----------------
    logic [255:0] mem [int unsigned];
    logic [31:0]  overlay [int unsigned];

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem.exists(la)) return mem[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la + 32'(w * 4)) ^ 32'h5A5A_0000;
        return l;
    endfunction

    function automatic logic [31:0] golden_word(input logic [31:0] a);
        logic [255:0] l;
        if (overlay.exists(a & ~32'h3)) return overlay[a & ~32'h3];
        l = mem_line(a & ~32'h1f);
        return l[{a[4:2], 5'b0} +: 32];
    endfunction

    bit           mdl_en = 1'b1;
    logic         mdl_ack;
    logic         man_ack = 1'b0;
    bit           busy;
    int           cnt;
    logic [31:0]  cur_addr;
    bit           cur_write;
    logic [255:0] cur_data;
    bit           stable_ok;
    int           n_rd = 0;
    int           n_wr = 0;
    logic [31:0]  last_rd_addr;
    logic [31:0]  last_wr_addr;
    int unsigned  rd_ack_cyc;

    assign mem_ack_i = mdl_ack | man_ack;

    initial begin
        mdl_ack    = 1'b0;
        mem_data_i = '0;
        busy       = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!mdl_en || rst_i) begin
                busy    = 1'b0;
                mdl_ack = 1'b0;
                continue;
            end
            if (mdl_ack) begin
                mdl_ack = 1'b0;
                busy    = 1'b0;
                if (cur_write) begin
                    check("enable held into read", 256'(mem_enable_o), 256'(1'b1));
                end else begin
                    mem_data_i = mem_line(cur_addr);
                    check("enable low after read ack", 256'(mem_enable_o), 256'(1'b0));
                end
            end
            if (busy) begin
                if (mem_addr_o !== cur_addr || mem_write_o !== cur_write || mem_enable_o !== 1'b1 ||
                    (cur_write && mem_data_o !== cur_data)) stable_ok = 1'b0;
            end else if (mem_enable_o === 1'b1) begin
                busy      = 1'b1;
                cur_addr  = mem_addr_o;
                cur_write = mem_write_o;
                cur_data  = mem_data_o;
                stable_ok = 1'b1;
                cnt       = int'($urandom_range(0, 3));
            end
            if (busy) begin
                if (cnt == 0) begin
                    mdl_ack = 1'b1;
                    check("mem outputs stable", 256'(stable_ok), 256'(1'b1));
                    if (cur_write) begin
                        mem[cur_addr] = cur_data;
                        n_wr++;
                        last_wr_addr = cur_addr;
                    end else begin
                        n_rd++;
                        last_rd_addr = cur_addr;
                        rd_ack_cyc   = cyc;
                        mem_data_i   = {8{cyc ^ 32'hBAD0_BAD0}};
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    // ---------------- CPU driver ----------------
    task automatic do_access(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr,
                             output logic [31:0] rdata, output bit first_stall,
                             output bit timed_out, output int unsigned done_cyc);
        @(negedge clk_i);
        p1_addr_i     = a;
        p1_data_i     = d;
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        #1;
        first_stall = (p1_stall_o !== 1'b0);
        for (int i = 0; i < 100 && p1_stall_o !== 1'b0; i++) begin
            @(negedge clk_i);
            #1;
        end
        timed_out = (p1_stall_o !== 1'b0);
        rdata     = p1_data_o;
        done_cyc  = cyc;
        @(posedge clk_i);
        #2;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    task automatic run_check(input string nm, input logic [31:0] a, input logic [31:0] d,
                             input bit rd, input bit wr, input logic [31:0] exp_data,
                             input bit exp_hit, input bit exp_wb, input logic [31:0] exp_wb_addr);
        int          wr0;
        int          rd0;
        logic [31:0] rdata;
        bit          fs;
        bit          to;
        int unsigned dc;
        wr0 = n_wr;
        rd0 = n_rd;
        do_access(a, d, rd, wr, rdata, fs, to, dc);
        $display("txn %s addr=%h rd=%0d wr=%0d wdata=%h rdata=%h first_stall=%0d", nm, a, rd, wr, d, rdata, fs);
        check({nm, " stall timeout"}, 256'(to), 256'(1'b0));
        if (to) return;
        check({nm, " hit"}, 256'(!fs), 256'(exp_hit));
        check({nm, " writebacks"}, 256'(n_wr - wr0), 256'(exp_wb ? 1 : 0));
        if (exp_wb) check({nm, " wb addr"}, 256'(last_wr_addr), 256'(exp_wb_addr));
        check({nm, " reads"}, 256'(n_rd - rd0), 256'(exp_hit ? 0 : 1));
        if (!exp_hit) begin
            check({nm, " rd addr"}, 256'(last_rd_addr), 256'(a & ~32'h1f));
            check({nm, " miss latency"}, 256'(dc), 256'(rd_ack_cyc + 2));
        end
        if (rd && !wr) check({nm, " load data"}, 256'(rdata), 256'(exp_data));
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          rd;
        bit          wr;
        logic [31:0] exp_data;
        bit          exp_hit;
        bit          exp_wb;
        logic [31:0] exp_wb_addr;
    } vec_t;

    bit          ref_valid [LINES];
    bit          ref_dirty [LINES];
    int unsigned ref_tag   [LINES];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit reached, expected run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs [8];
        logic [255:0] ln;
        logic [31:0]  a;
        logic [31:0]  d;
        logic [31:0]  ed;
        logic [31:0]  wba;
        int unsigned  t;
        int unsigned  ix;
        int unsigned  w;
        int unsigned  op;
        bit           hit;
        bit           wb;
        bit           rd;
        bit           wr;

        rst_i         = 1'b1;
        p1_addr_i     = '0;
        p1_data_i     = '0;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
        for (int k = 0; k < 8; k++) ln[k*32 +: 32] = 32'(32'h1111_1111 * (k + 1));
        mem[32'h40] = ln;

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("reset mem_enable_o", 256'(mem_enable_o), 256'(1'b0));
        check("reset mem_write_o", 256'(mem_write_o), 256'(1'b0));
        check("reset mem_addr_o", 256'(mem_addr_o), 256'(32'h0));
        check("reset mem_data_o", mem_data_o, 256'(0));
        check("reset p1_stall_o", 256'(p1_stall_o), 256'(1'b0));

        vecs[0] = '{32'h0000_0040, 32'h0,         1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{32'h0000_0044, 32'h0,         1'b1, 1'b0, 32'h2222_2222, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{32'h0000_0048, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[3] = '{32'h0000_0048, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
        vecs[4] = '{32'h0000_0440, 32'h0,         1'b1, 1'b0, 32'h5A5A_0440, 1'b0, 1'b1, 32'h40};
        vecs[5] = '{32'h0000_0080, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[6] = '{32'h0000_0080, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
        vecs[7] = '{32'h0000_0880, 32'h0,         1'b1, 1'b0, 32'h5A5A_0880, 1'b0, 1'b1, 32'h80};
        for (int i = 0; i < 8; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr,
                      vecs[i].exp_data, vecs[i].exp_hit, vecs[i].exp_wb, vecs[i].exp_wb_addr);
        end

        // Backing memory after the two write-backs.
        ln = mem_line(32'h40);
        check("mem 0x48 after writeback", 256'(ln[95:64]), 256'(32'hDEAD_BEEF));
        check("mem 0x40 after writeback", 256'(ln[31:0]), 256'(32'h1111_1111));
        ln = mem_line(32'h80);
        check("mem 0x80 after writeback", 256'(ln[31:0]), 256'(32'hCAFE_F00D));

        // Reset in the middle of a read transaction, then a late ack.
        mdl_en = 1'b0;
        @(negedge clk_i);
        p1_addr_i    = 32'h40;
        p1_MemRead_i = 1'b1;
        #1;
        for (int i = 0; i < 10 && mem_enable_o !== 1'b1; i++) begin
            @(negedge clk_i);
            #1;
        end
        check("abort enable", 256'(mem_enable_o), 256'(1'b1));
        check("abort write", 256'(mem_write_o), 256'(1'b0));
        check("abort addr", 256'(mem_addr_o), 256'(32'h40));
        @(negedge clk_i);
        rst_i        = 1'b1;
        p1_MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("post-reset enable", 256'(mem_enable_o), 256'(1'b0));
        check("post-reset stall", 256'(p1_stall_o), 256'(1'b0));
        man_ack = 1'b1;
        @(negedge clk_i);
        man_ack = 1'b0;
        #1;
        check("late ack enable", 256'(mem_enable_o), 256'(1'b0));
        check("late ack stall", 256'(p1_stall_o), 256'(1'b0));
        check("late ack addr", 256'(mem_addr_o), 256'(32'h0));
        mdl_en = 1'b1;
        run_check("reload", 32'h40, 32'h0, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 32'h0);

        // Clean start for the randomized run.
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_tag[i]   = 0;
        end
        for (int k = 0; k < 300; k++) begin
            t   = $urandom_range(0, 3);
            ix  = $urandom_range(0, 3);
            w   = $urandom_range(0, 7);
            op  = $urandom_range(0, 2);
            a   = 32'((t << 10) | (ix << 5) | (w << 2));
            d   = $urandom;
            rd  = (op != 1);
            wr  = (op != 0);
            hit = ref_valid[ix] && (ref_tag[ix] == t);
            wb  = !hit && ref_valid[ix] && ref_dirty[ix];
            wba = 32'((ref_tag[ix] << 10) | (ix << 5));
            ed  = golden_word(a);
            run_check($sformatf("rnd%0d", k), a, d, rd, wr, ed, hit, wb, wba);
            if (!hit) begin
                ref_valid[ix] = 1'b1;
                ref_tag[ix]   = t;
                ref_dirty[ix] = 1'b0;
            end
            if (wr) begin
                ref_dirty[ix] = 1'b1;
                overlay[a]    = d;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
